// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM states, flag indices.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_XOR = 4'b0001,
        OP_SUB = 4'b0010,
        OP_RSB = 4'b0011,
        OP_ADD = 4'b0100,
        OP_LSL = 4'b0101,
        OP_LSR = 4'b0110,
        OP_ASR = 4'b0111,
        OP_MUL = 4'b1001,
        OP_ORR = 4'b1100,
        OP_MOV = 4'b1101
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Bit positions inside the {N,Z,C,V} flag register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bus of the iterative ALU; the block is the slave side.
interface alu_iter_if #(
    parameter int N = 32
) ();

    logic         valid_i;
    logic         ready_o;
    logic [3:0]   op_i;
    logic [N-1:0] operand_a_i;
    logic [N-1:0] operand_b_i;
    logic         set_flags_i;
    logic         valid_o;
    logic         ready_i;
    logic [N-1:0] result_o;
    logic [3:0]   nzcv_o;

    modport slave (
        input  valid_i, op_i, operand_a_i, operand_b_i, set_flags_i, ready_i,
        output ready_o, valid_o, result_o, nzcv_o
    );

    modport master (
        output valid_i, op_i, operand_a_i, operand_b_i, set_flags_i, ready_i,
        input  ready_o, valid_o, result_o, nzcv_o
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU for the single-cycle operations and their flags.
// Opcodes it does not implement give a zero result and pass flags through.
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   nzcv_in,
    output logic [N-1:0] result,
    output logic [3:0]   nzcv_out
);

    logic [N-1:0] add_x;
    logic [N-1:0] add_y;
    logic         add_cin;
    logic [N:0]   sum;
    logic         use_add;
    logic         use_logic;

    // Subtraction is x + ~y + 1 so carry and overflow share the adder path
    always_comb begin
        result    = '0;
        nzcv_out  = nzcv_in;
        add_x     = '0;
        add_y     = '0;
        add_cin   = 1'b0;
        use_add   = 1'b0;
        use_logic = 1'b0;
        sum       = '0;
        case (op)
            OP_ADD: begin add_x = a; add_y = b;  add_cin = 1'b0; use_add = 1'b1; end
            OP_SUB: begin add_x = a; add_y = ~b; add_cin = 1'b1; use_add = 1'b1; end
            OP_RSB: begin add_x = b; add_y = ~a; add_cin = 1'b1; use_add = 1'b1; end
            OP_AND: begin result = a & b; use_logic = 1'b1; end
            OP_XOR: begin result = a ^ b; use_logic = 1'b1; end
            OP_ORR: begin result = a | b; use_logic = 1'b1; end
            OP_MOV: begin result = b;     use_logic = 1'b1; end
            default: ;
        endcase
        if (use_add) begin
            sum              = {1'b0, add_x} + {1'b0, add_y} + {{N{1'b0}}, add_cin};
            result           = sum[N-1:0];
            nzcv_out[FLAG_N] = sum[N-1];
            nzcv_out[FLAG_Z] = (sum[N-1:0] == '0);
            nzcv_out[FLAG_C] = sum[N];
            nzcv_out[FLAG_V] = (add_x[N-1] == add_y[N-1]) && (sum[N-1] != add_x[N-1]);
        end
        if (use_logic) begin
            nzcv_out[FLAG_N] = result[N-1];
            nzcv_out[FLAG_Z] = (result == '0);
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle ops through alu, shifts one bit per cycle,
// optional shift-add multiplier enabled by macro ALU_ITER_MUL_EN.
module alu_iter
    import alu_pkg::*;
#(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_iter_if.slave  bus
);

    localparam int CW = SW + 1;

    state_e        state;
    logic          ready_q;
    logic          valid_q;
    logic [3:0]    op_q;
    logic          sf_q;
    logic [N-1:0]  work_a;
    logic [N-1:0]  result_q;
    logic [3:0]    nzcv_q;
    logic [CW-1:0] count;
    logic [SW-1:0] amount;
`ifdef ALU_ITER_MUL_EN
    logic [N-1:0]  work_b;
    logic [N-1:0]  acc;
`endif

    logic [N-1:0]  alu_result;
    logic [3:0]    alu_nzcv;
    logic [N-1:0]  step_val;
    logic          step_out;

    assign amount      = bus.operand_b_i[SW-1:0];
    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.result_o = result_q;
    assign bus.nzcv_o  = nzcv_q;

    alu #(.N(N)) u_alu (
        .op       (bus.op_i),
        .a        (bus.operand_a_i),
        .b        (bus.operand_b_i),
        .nzcv_in  (nzcv_q),
        .result   (alu_result),
        .nzcv_out (alu_nzcv)
    );

    // Value after one iteration step; for MUL it is the next accumulator
    always_comb begin
        step_val = work_a;
        step_out = 1'b0;
        case (op_q)
            OP_LSL: begin step_val = {work_a[N-2:0], 1'b0};         step_out = work_a[N-1]; end
            OP_LSR: begin step_val = {1'b0, work_a[N-1:1]};         step_out = work_a[0];   end
            OP_ASR: begin step_val = {work_a[N-1], work_a[N-1:1]};  step_out = work_a[0];   end
`ifdef ALU_ITER_MUL_EN
            OP_MUL: step_val = work_b[0] ? (acc + work_a) : acc;
`endif
            default: ;
        endcase
    end

    // Handshake FSM with registered outputs, iteration and flag update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            nzcv_q   <= '0;
            count    <= '0;
            op_q     <= '0;
            sf_q     <= 1'b0;
            work_a   <= '0;
`ifdef ALU_ITER_MUL_EN
            work_b   <= '0;
            acc      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        op_q    <= bus.op_i;
                        sf_q    <= bus.set_flags_i;
                        work_a  <= bus.operand_a_i;
                        ready_q <= 1'b0;
                        if (is_shift(bus.op_i)) begin
                            if (amount == '0) begin
                                state    <= DONE;
                                valid_q  <= 1'b1;
                                result_q <= bus.operand_a_i;
                                if (bus.set_flags_i) begin
                                    nzcv_q[FLAG_N] <= bus.operand_a_i[N-1];
                                    nzcv_q[FLAG_Z] <= (bus.operand_a_i == '0);
                                end
                            end else begin
                                state <= BUSY;
                                count <= {1'b0, amount};
                            end
                        end
`ifdef ALU_ITER_MUL_EN
                        else if (bus.op_i == OP_MUL) begin
                            state  <= BUSY;
                            count  <= CW'(N);
                            work_b <= bus.operand_b_i;
                            acc    <= '0;
                        end
`endif
                        else begin
                            state    <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= alu_result;
                            if (bus.set_flags_i) begin
                                nzcv_q <= alu_nzcv;
                            end
                        end
                    end
                end
                BUSY: begin
                    count <= count - CW'(1);
`ifdef ALU_ITER_MUL_EN
                    if (op_q == OP_MUL) begin
                        acc    <= step_val;
                        work_a <= work_a << 1;
                        work_b <= work_b >> 1;
                    end else begin
                        work_a <= step_val;
                    end
`else
                    work_a <= step_val;
`endif
                    if (count == CW'(1)) begin
                        state    <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= step_val;
                        if (sf_q) begin
                            nzcv_q[FLAG_N] <= step_val[N-1];
                            nzcv_q[FLAG_Z] <= (step_val == '0);
                            if (is_shift(op_q)) begin
                                nzcv_q[FLAG_C] <= step_out;
                            end
                        end
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (N=32): directed corner cases followed by
// randomized requests against a behavioural model. Honors ALU_ITER_MUL_EN.
module tb_alu_iter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [3:0]  exp_nzcv;
    logic [31:0] last_result;
    logic [3:0]  last_nzcv;
    int          last_lat;

    alu_iter_if #(.N(32)) bus ();

    alu_iter #(.N(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Reference model computed from plain arithmetic on the operands
    function automatic void refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic sf, input logic [3:0] nz_in,
                                     output logic [31:0] res, output logic [3:0] nz_out, output int lat);
        logic        c;
        logic        v;
        logic        upd;
        longint      sa;
        longint      sb;
        longint      s;
        logic [32:0] wide;
        logic [63:0] prod;
        int          k;
        res  = '0;
        lat  = 1;
        c    = nz_in[1];
        v    = nz_in[0];
        upd  = 1'b0;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        k    = int'(b[4:0]);
        case (op)
            4'h0: begin res = a & b; upd = 1'b1; end
            4'h1: begin res = a ^ b; upd = 1'b1; end
            4'hC: begin res = a | b; upd = 1'b1; end
            4'hD: begin res = b;     upd = 1'b1; end
            4'h4: begin
                wide = {1'b0, a} + {1'b0, b};
                res = wide[31:0]; c = wide[32];
                s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                upd = 1'b1;
            end
            4'h2: begin
                res = a - b; c = (a >= b);
                s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                upd = 1'b1;
            end
            4'h3: begin
                res = b - a; c = (b >= a);
                s = sb - sa; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                upd = 1'b1;
            end
            4'h5, 4'h6, 4'h7: begin
                lat = k + 1;
                upd = 1'b1;
                if (k == 0) begin
                    res = a;
                end else if (op == 4'h5) begin
                    res = a << k; c = a[32 - k];
                end else if (op == 4'h6) begin
                    res = a >> k; c = a[k - 1];
                end else begin
                    res = $signed(a) >>> k; c = a[k - 1];
                end
            end
`ifdef ALU_ITER_MUL_EN
            4'h9: begin
                prod = {32'b0, a} * {32'b0, b};
                res = prod[31:0]; lat = 33; upd = 1'b1;
            end
`endif
            default: begin res = '0; prod = '0; end
        endcase
        nz_out = nz_in;
        if (sf && upd) begin
            nz_out = {res[31], (res == 32'd0), c, v};
        end
    endfunction

    // One full request/response transaction checked against the model
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic sf, input int hold, input bit pulse_valid);
        logic [31:0] er;
        logic [3:0]  en;
        int          el;
        int          lat;
        int          guard;
        refModel(op, a, b, sf, exp_nzcv, er, en, el);
        @(negedge clk);
        guard = 0;
        while (bus.ready_o !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_req", {63'b0, bus.ready_o}, 64'd1);
        bus.valid_i     = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.set_flags_i = sf;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        last_result = bus.result_o;
        last_nzcv   = bus.nzcv_o;
        last_lat    = lat;
        checkOutput($sformatf("latency op=%0h", op), 64'(lat), 64'(el));
        checkOutput($sformatf("result op=%0h", op), {32'b0, bus.result_o}, {32'b0, er});
        checkOutput($sformatf("nzcv op=%0h", op), {60'b0, bus.nzcv_o}, {60'b0, en});
        checkOutput("ready_low_in_done", {63'b0, bus.ready_o}, 64'd0);
        exp_nzcv = en;
        for (int i = 0; i < hold; i++) begin
            if (pulse_valid && i == 0) begin
                bus.valid_i = 1'b1;
                bus.op_i    = 4'h4;
            end
            @(posedge clk);
            #1;
            bus.valid_i = 1'b0;
            checkOutput("hold_valid", {63'b0, bus.valid_o}, 64'd1);
            checkOutput("hold_result", {32'b0, bus.result_o}, {32'b0, er});
            checkOutput("hold_ready", {63'b0, bus.ready_o}, 64'd0);
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        checkOutput("valid_after_handshake", {63'b0, bus.valid_o}, 64'd0);
        checkOutput("ready_after_handshake", {63'b0, bus.ready_o}, 64'd1);
        if (pulse_valid) begin
            @(posedge clk);
            #1;
            checkOutput("pulse_not_accepted", {63'b0, bus.valid_o}, 64'd0);
        end
    endtask

    // Start a request and reset the block in the given cycle after accept
    task automatic resetDuring(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int cyc);
        @(negedge clk);
        bus.valid_i     = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.set_flags_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (cyc - 1) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_valid", {63'b0, bus.valid_o}, 64'd0);
        checkOutput("rst_nzcv", {60'b0, bus.nzcv_o}, 64'd0);
        checkOutput("rst_result", {32'b0, bus.result_o}, 64'd0);
        exp_nzcv = 4'b0000;
        @(posedge clk);
        #1;
        checkOutput("ready_after_rst", {63'b0, bus.ready_o}, 64'd1);
        checkOutput("no_result_after_rst", {63'b0, bus.valid_o}, 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks          = 0;
        failures        = 0;
        exp_nzcv        = 4'b0000;
        rst             = 1'b1;
        bus.valid_i     = 1'b0;
        bus.ready_i     = 1'b0;
        bus.op_i        = 4'h0;
        bus.operand_a_i = '0;
        bus.operand_b_i = '0;
        bus.set_flags_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", {63'b0, bus.valid_o}, 64'd0);
        checkOutput("reset_ready", {63'b0, bus.ready_o}, 64'd1);
        checkOutput("reset_result", {32'b0, bus.result_o}, 64'd0);
        checkOutput("reset_nzcv", {60'b0, bus.nzcv_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(4'h5, 32'h8000_0001, 32'd1, 1'b1, 0, 1'b0);
        checkOutput("lsl_result", {32'b0, last_result}, 64'h2);
        checkOutput("lsl_nzcv", {60'b0, last_nzcv}, 64'b0010);
        checkOutput("lsl_latency", 64'(last_lat), 64'd2);

        applyStimulus(4'h7, 32'h8000_0000, 32'd31, 1'b0, 0, 1'b0);
        checkOutput("asr_result", {32'b0, last_result}, 64'hFFFF_FFFF);

        applyStimulus(4'h4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 0, 1'b0);
        checkOutput("add_result", {32'b0, last_result}, 64'h8000_0000);
        checkOutput("add_nzcv", {60'b0, last_nzcv}, 64'b1001);
        checkOutput("add_latency", 64'(last_lat), 64'd1);

        applyStimulus(4'h2, 32'd5, 32'd5, 1'b0, 0, 1'b0);
        checkOutput("sub_noflag_result", {32'b0, last_result}, 64'd0);
        checkOutput("sub_noflag_nzcv", {60'b0, last_nzcv}, 64'b1001);

        applyStimulus(4'h9, 32'h0001_0000, 32'h0001_0000, 1'b1, 0, 1'b0);
        checkOutput("mul_result", {32'b0, last_result}, 64'd0);
`ifdef ALU_ITER_MUL_EN
        checkOutput("mul_nzcv", {60'b0, last_nzcv}, 64'b0101);
        checkOutput("mul_latency", 64'(last_lat), 64'd33);
`else
        checkOutput("mul_nzcv", {60'b0, last_nzcv}, 64'b1001);
        checkOutput("mul_latency", 64'(last_lat), 64'd1);
`endif

        applyStimulus(4'hC, 32'h00F0_0000, 32'h0000_000F, 1'b1, 5, 1'b1);

        resetDuring(4'h9, 32'h1234_5678, 32'h0000_0003, 10);
        applyStimulus(4'h4, 32'd2, 32'd3, 1'b1, 0, 1'b0);
        checkOutput("add_after_rst", {32'b0, last_result}, 64'd5);

        for (int t = 0; t < 60; t++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = pickOperand();
            b  = pickOperand();
            applyStimulus(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
